// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between the instruction-fetch
// port and the load/store port. One requester is chosen per address handshake and held
// until it is accepted; an in-order owner queue steers each data_ok/rdata back to the
// requester that issued it. A wait counter bounds how long inst can lose to data.
module sram_req_arbiter #(
  parameter int unsigned OUTS_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        resetn_i,

  // Instruction port
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,

  // Load/store port
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,

  // Shared memory port
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PtrW    = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT) + 1;

  localparam logic [CntW-1:0]    FullCnt   = CntW'(OUTS_DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StLockI, StLockD} state_e;

  state_e state_q, state_d;

  // Owner queue: 0 = inst, 1 = data
  logic [OUTS_DEPTH-1:0] owner_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [StarveW-1:0]    starve_q, starve_d;

  logic sel_data;    // 1 when the data port drives the memory port
  logic sel_req;     // request of the selected port
  logic force_inst;
  logic fifo_empty;
  logic fifo_full;
  logic stall;
  logic push;
  logic pop;
  logic head_owner;
  logic inst_hs;

  assign force_inst = (starve_q == StarveMax);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FullCnt);
  assign head_owner = owner_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full queue can still take a new request.
  assign stall = fifo_full && !mem_data_ok_i;

  assign push    = mem_req_o && mem_addr_ok_i;
  assign pop     = resetn_i && mem_data_ok_i && !fifo_empty;
  assign inst_hs = push && !sel_data;

  // Grant state register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next grant state: lock onto a winner that is not accepted, release on accept or drop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sel_req && !push) begin
          state_d = sel_data ? StLockD : StLockI;
        end
      end
      StLockI, StLockD: begin
        if (!sel_req || push) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Selection and shared-port outputs; the lock states pin the mux to one requester
  always_comb begin
    sel_data = 1'b0;
    unique case (state_q)
      StLockI: sel_data = 1'b0;
      StLockD: sel_data = 1'b1;
      default: begin
        if (data_req_i && !force_inst) begin
          sel_data = 1'b1;
        end else if (inst_req_i) begin
          sel_data = 1'b0;
        end else begin
          sel_data = data_req_i;
        end
      end
    endcase

    sel_req = sel_data ? data_req_i : inst_req_i;

    mem_req_o   = resetn_i && sel_req && !stall;
    mem_wr_o    = sel_data ? data_wr_i    : inst_wr_i;
    mem_size_o  = sel_data ? data_size_i  : inst_size_i;
    mem_wstrb_o = sel_data ? data_wstrb_i : inst_wstrb_i;
    mem_addr_o  = sel_data ? data_addr_i  : inst_addr_i;
    mem_wdata_o = sel_data ? data_wdata_i : inst_wdata_i;

    inst_addr_ok_o = resetn_i && mem_addr_ok_i && !stall && !sel_data;
    data_addr_ok_o = resetn_i && mem_addr_ok_i && !stall &&  sel_data;
  end

  // Response routing: head of the owner queue picks the receiver, rdata goes to both
  always_comb begin
    inst_data_ok_o = pop && !head_owner;
    data_data_ok_o = pop &&  head_owner;
    inst_rdata_o   = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

  // Owner queue occupancy; push and pop together leave it unchanged
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Owner queue storage and pointers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel_data;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Inst wait counter: counts cycles inst waits unaccepted, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!inst_req_i || inst_hs) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // Inst wait counter register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference model of the arbitration rules.
module tb_sram_req_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;
  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .OUTS_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .inst_req_i    (inst_req),
    .inst_wr_i     (inst_wr),
    .inst_size_i   (inst_size),
    .inst_wstrb_i  (inst_wstrb),
    .inst_addr_i   (inst_addr),
    .inst_wdata_i  (inst_wdata),
    .inst_addr_ok_o(inst_addr_ok),
    .inst_data_ok_o(inst_data_ok),
    .inst_rdata_o  (inst_rdata),
    .data_req_i    (data_req),
    .data_wr_i     (data_wr),
    .data_size_i   (data_size),
    .data_wstrb_i  (data_wstrb),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_addr_ok_o(data_addr_ok),
    .data_data_ok_o(data_data_ok),
    .data_rdata_o  (data_rdata),
    .mem_req_o     (mem_req),
    .mem_wr_o      (mem_wr),
    .mem_size_o    (mem_size),
    .mem_wstrb_o   (mem_wstrb),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_addr_ok_i (mem_addr_ok),
    .mem_data_ok_i (mem_data_ok),
    .mem_rdata_i   (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner list in issue order, who (if anyone) holds the port, wait count
  bit mq[$];
  int lock_m   = -1;
  int starve_m = 0;

  // Outputs observed in the most recent cycle, for the directed checks
  logic o_iaok, o_daok, o_idok, o_ddok, o_mreq;
  logic [31:0] o_maddr, o_irdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ir, input bit dr, input bit aok, input bit dok,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] rd);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    inst_addr   = ia;
    data_addr   = da;
    mem_rdata   = rd;
    inst_wr     = 1'($urandom);
    data_wr     = 1'($urandom);
    inst_size   = 2'($urandom);
    data_size   = 2'($urandom);
    inst_wstrb  = 4'($urandom);
    data_wstrb  = 4'($urandom);
    inst_wdata  = $urandom;
    data_wdata  = $urandom;
  endtask

  // Check one cycle against the model, advance the model, move to just after the next edge
  task automatic tick();
    bit sd, sr, popm, acc, hs;
    logic [31:0] e_addr, e_wdata, e_ctl;
    #3;
    o_iaok = inst_addr_ok; o_daok = data_addr_ok;
    o_idok = inst_data_ok; o_ddok = data_data_ok;
    o_mreq = mem_req;      o_maddr = mem_addr;   o_irdata = inst_rdata;
    if (!resetn) begin
      mq.delete();
      lock_m   = -1;
      starve_m = 0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
    end else begin
      if (lock_m >= 0)                           sd = (lock_m == 1);
      else if (data_req && starve_m != LIMIT)    sd = 1'b1;
      else if (inst_req)                         sd = 1'b0;
      else                                       sd = data_req;
      sr   = sd ? data_req : inst_req;
      popm = mem_data_ok && (mq.size() > 0);
      acc  = (mq.size() < DEPTH) || popm;
      hs   = sr && acc && mem_addr_ok;

      chk("mem_req", mem_req, 32'(sr && acc));
      chk("inst_addr_ok", inst_addr_ok, 32'(!sd && mem_addr_ok && acc));
      chk("data_addr_ok", data_addr_ok, 32'(sd && mem_addr_ok && acc));
      chk("inst_data_ok", inst_data_ok, 32'(popm && mq[0] == 1'b0));
      chk("data_data_ok", data_data_ok, 32'(popm && mq[0] == 1'b1));
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      if (sr && acc) begin
        e_addr  = sd ? data_addr : inst_addr;
        e_wdata = sd ? data_wdata : inst_wdata;
        e_ctl   = sd ? {25'd0, data_wr, data_size, data_wstrb}
                     : {25'd0, inst_wr, inst_size, inst_wstrb};
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, e_ctl);
      end

      if (popm) void'(mq.pop_front());
      if (hs) mq.push_back(sd);
      lock_m = (sr && !hs) ? int'(sd) : -1;
      if (!inst_req || (hs && !sd)) starve_m = 0;
      else if (starve_m < LIMIT)    starve_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && mq.size() > 0; i++) begin
      drive(0, 0, 0, 1, IA, DA, $urandom);
      tick();
    end
    chk("drain_done", 32'(mq.size()), 0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, IA, DA, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    drive(0, 0, 0, 0, IA, DA, 32'd0);
    tick();

    // Single inst read: accepted at once, answered two cycles later
    drive(1, 0, 1, 0, IA, DA, 32'd0);
    tick();
    chk("t1_inst_addr_ok", o_iaok, 1);
    drive(0, 0, 0, 0, IA, DA, 32'd0);
    tick();
    drive(0, 0, 0, 1, IA, DA, 32'h0280_0400);
    tick();
    chk("t1_inst_data_ok", o_idok, 1);
    chk("t1_inst_rdata", o_irdata, 32'h0280_0400);
    chk("t1_data_data_ok", o_ddok, 0);

    // Both requesting: data wins LIMIT handshakes, then inst, then data again
    for (int c = 0; c <= int'(LIMIT) + 1; c++) begin
      drive(1, 1, 1, 1, IA, DA, $urandom);
      tick();
      chk($sformatf("t2_inst_win_%0d", c), o_iaok, 32'(c == int'(LIMIT)));
      chk($sformatf("t2_data_win_%0d", c), o_daok, 32'(c != int'(LIMIT)));
    end
    drain();

    // Inst locked while data rises: mux stays on inst until accepted
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, c > 0, c >= 3, 0, IA, DA, $urandom);
      tick();
      if (c < 4) chk($sformatf("t3_mem_addr_%0d", c), o_maddr, IA);
      chk($sformatf("t3_inst_aok_%0d", c), o_iaok, 32'(c == 3));
      chk($sformatf("t3_data_aok_%0d", c), o_daok, 32'(c == 4));
    end
    drain();

    // Fill with I,D,D,I; fifth stalls; responses route in order
    for (int c = 0; c < 4; c++) begin
      drive(c == 0 || c == 3, c == 1 || c == 2, 1, 0, IA, DA, $urandom);
      tick();
      chk($sformatf("t4_accept_%0d", c), o_iaok | o_daok, 1);
    end
    drive(1, 0, 1, 0, IA, DA, $urandom);
    tick();
    chk("t4_full_mem_req", o_mreq, 0);
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, IA, DA, $urandom);
      tick();
      chk($sformatf("t4_inst_dok_%0d", c), o_idok, 32'(c == 0 || c == 3));
      chk($sformatf("t4_data_dok_%0d", c), o_ddok, 32'(c == 1 || c == 2));
    end

    // Full queue: pop and push in the same cycle, occupancy stays at the limit
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 1, 0, IA, DA, $urandom);
      tick();
    end
    drive(0, 1, 1, 1, IA, DA, $urandom);
    tick();
    chk("t5_data_aok", o_daok, 1);
    chk("t5_inst_dok", o_idok, 1);
    drive(0, 1, 1, 0, IA, DA, $urandom);
    tick();
    chk("t5_still_full", o_mreq, 0);
    drain();

    // Reset with two outstanding, then a stray response after release
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 0, IA, DA, $urandom);
      tick();
    end
    resetn = 1'b0;
    drive(1, 1, 1, 1, IA, DA, $urandom);
    tick();
    chk("t6_rst_mem_req", o_mreq, 0);
    chk("t6_rst_inst_dok", o_idok, 0);
    resetn = 1'b1;
    drive(0, 0, 0, 1, IA, DA, $urandom);
    tick();
    chk("t6_stray_inst_dok", o_idok, 0);
    chk("t6_stray_data_dok", o_ddok, 0);
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 1, 0, IA, DA, $urandom);
      tick();
      chk($sformatf("t6_refill_%0d", c), o_iaok, 32'(c < 4));
    end
    drain();

    // Random traffic, occasional reset and stray responses
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom),
            (mq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 49) == 0),
            $urandom, $urandom, $urandom);
      tick();
    end
    resetn = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
